// File: rtl/spi_mel_readout_ctrl.sv
// Buffers one mel-spectrogram frame from the decoder and streams it to the host
// over an oversampled mode-0 SPI slave link, MSB first, mel-major order.
`timescale 1ns/1ps
module spi_mel_readout_ctrl #(
  parameter int unsigned DATA_WIDTH         = 16,
  parameter int unsigned N_MELS             = 2,
  parameter int unsigned FIXED_FRAMES_FINAL = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_in_valid,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  o_in_ready,
  input  logic                  i_cs_n,
  input  logic                  i_sclk,
  input  logic                  i_mosi,
  output logic                  o_miso,
  output logic                  o_frame_ready,
  output logic                  o_xfer_abort,
  output logic                  o_underrun
);

  localparam int unsigned TOTAL_WORDS = N_MELS * FIXED_FRAMES_FINAL;
  localparam int unsigned PTR_W       = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;
  localparam int unsigned BIT_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {S_FILL, S_FULL, S_XMIT, S_DONE} state_t;

  state_t                r_state, w_state_n;
  logic [DATA_WIDTH-1:0] r_buf [TOTAL_WORDS];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_word;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic                  r_cs_s1, r_cs_s2, r_cs_d;
  logic                  r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic                  r_post_rst, r_cs_arm;
  logic                  r_miso, r_frame_ready, r_in_ready, r_xfer_abort, r_underrun;
  logic                  w_cs_fall, w_cs_rise, w_sclk_fall;
  logic                  w_accept, w_start, w_shift, w_abort, w_rearm;
  logic                  w_last_bit, w_last_word;
  logic                  w_unused_mosi;

  assign w_unused_mosi = i_mosi;

  // Two-stage synchronizers plus edge-detect stage on the host pins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cs_s1    <= 1'b1;
      r_cs_s2    <= 1'b1;
      r_cs_d     <= 1'b1;
      r_sclk_s1  <= 1'b0;
      r_sclk_s2  <= 1'b0;
      r_sclk_d   <= 1'b0;
      r_post_rst <= 1'b0;
      r_cs_arm   <= 1'b0;
    end else begin
      r_cs_s1    <= i_cs_n;
      r_cs_s2    <= r_cs_s1;
      r_cs_d     <= r_cs_s2;
      r_sclk_s1  <= i_sclk;
      r_sclk_s2  <= r_sclk_s1;
      r_sclk_d   <= r_sclk_s2;
      r_post_rst <= 1'b1;
      // A cs_n fall only counts once the pin itself has been seen high after reset.
      if (r_post_rst && r_cs_s1) r_cs_arm <= 1'b1;
    end
  end

  assign w_cs_fall   = r_cs_arm & r_cs_d & ~r_cs_s2;
  assign w_cs_rise   = ~r_cs_d & r_cs_s2;
  assign w_sclk_fall = r_sclk_d & ~r_sclk_s2;
  assign w_last_bit  = (r_bit_cnt == '0);
  assign w_last_word = (r_rd_word == PTR_W'(TOTAL_WORDS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_FILL;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_accept  = 1'b0;
    w_start   = 1'b0;
    w_shift   = 1'b0;
    w_abort   = 1'b0;
    w_rearm   = 1'b0;
    case (r_state)
      S_FILL: begin
        w_accept = i_in_valid;
        if (i_in_valid && (r_wr_ptr == PTR_W'(TOTAL_WORDS - 1))) w_state_n = S_FULL;
      end
      S_FULL: begin
        if (w_cs_fall) begin
          w_start   = 1'b1;
          w_state_n = S_XMIT;
        end
      end
      S_XMIT: begin
        // Abort takes priority over a coincident sclk fall.
        if (w_cs_rise) begin
          w_abort   = 1'b1;
          w_state_n = S_FULL;
        end else if (w_sclk_fall) begin
          w_shift = 1'b1;
          if (w_last_bit && w_last_word) w_state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (w_cs_rise) begin
          w_rearm   = 1'b1;
          w_state_n = S_FILL;
        end
      end
      default: w_state_n = S_FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) r_buf[r_wr_ptr] <= i_in_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr      <= '0;
      r_rd_word     <= '0;
      r_bit_cnt     <= '0;
      r_shreg       <= '0;
      r_miso        <= 1'b0;
      r_frame_ready <= 1'b0;
      r_in_ready    <= 1'b1;
      r_xfer_abort  <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      if (w_accept)     r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      else if (w_rearm) r_wr_ptr <= '0;

      if (w_start) begin
        r_shreg   <= r_buf[0];
        r_rd_word <= '0;
        r_bit_cnt <= BIT_W'(DATA_WIDTH - 1);
      end else if (w_shift) begin
        if (w_last_bit && !w_last_word) begin
          r_shreg   <= r_buf[r_rd_word + PTR_W'(1)];
          r_rd_word <= r_rd_word + PTR_W'(1);
          r_bit_cnt <= BIT_W'(DATA_WIDTH - 1);
        end else begin
          r_shreg   <= r_shreg << 1;
          r_bit_cnt <= r_bit_cnt - BIT_W'(1);
        end
      end

      if (r_state == S_FILL && w_cs_fall)      r_underrun <= 1'b1;
      else if (r_state == S_FULL && w_cs_fall) r_underrun <= 1'b0;

      r_miso        <= (r_state == S_XMIT) && !r_cs_s2 && r_shreg[DATA_WIDTH-1];
      r_frame_ready <= (w_state_n != S_FILL);
      r_in_ready    <= (w_state_n == S_FILL);
      r_xfer_abort  <= w_abort;
    end
  end

  assign o_miso        = r_miso;
  assign o_frame_ready = r_frame_ready;
  assign o_in_ready    = r_in_ready;
  assign o_xfer_abort  = r_xfer_abort;
  assign o_underrun    = r_underrun;

endmodule

// File: doc/spi_mel_readout_ctrl.md
# spi_mel_readout_ctrl

System-clock controller that sequences decoder mel-spectrogram output into a frame buffer and schedules its readout over the SPI slave link. It accepts one `N_MELS x FIXED_FRAMES_FINAL` frame of signed words from the decoder through a valid/ready handshake. It then raises `frame_ready` to the host and, when the host drops `cs_n`, shifts the whole frame out on `miso`, MSB first, in mel-major order. `sclk` and `cs_n` are oversampled in the `clk` domain, so no logic runs on `sclk`.

## Interface
- `DATA_WIDTH`, 16, bits per mel word
- `N_MELS`, 2, mel bins per frame
- `FIXED_FRAMES_FINAL`, 4, time frames per mel bin; `TOTAL_WORDS = N_MELS*FIXED_FRAMES_FINAL`
- `clk  in  1` system clock; one clock, all state on rising edge; requires `f_clk >= 8*f_sclk`
- `rst  in  1` synchronous, active-high reset
- `in_valid  in  1` decoder word valid
- `in_data  in  DATA_WIDTH` signed decoder word, mel-major order (`idx = mel*FIXED_FRAMES_FINAL + frame`)
- `in_ready  out  1` buffer accepting words
- `cs_n  in  1` SPI chip select from host, asynchronous
- `sclk  in  1` SPI clock from host, asynchronous, mode 0
- `mosi  in  1` unused, ignored
- `miso  out  1` serial data to host
- `frame_ready  out  1` full frame buffered, awaiting readout
- `xfer_abort  out  1` one-cycle pulse: `cs_n` rose before all bits sent
- `underrun  out  1` sticky: `cs_n` fell while frame not ready

## Operation
- Input sync: `cs_n` and `sclk` each pass through 2 FFs plus 1 edge-detect FF. Sync FFs reset to `cs_n=1`, `sclk=0`.
- Storage: buffer of `TOTAL_WORDS x DATA_WIDTH`, write pointer `wr_ptr` of `$clog2(TOTAL_WORDS)` bits.
- Readout counters: word counter `rd_word`, bit counter `bit_cnt` from `DATA_WIDTH-1` down to 0, shift register `shreg`.
- FILL state
  - `in_ready=1`. Accept on `in_valid & in_ready`: write `buf[wr_ptr]`, increment `wr_ptr`.
  - Accept at `wr_ptr==TOTAL_WORDS-1` -> FULL.
  - A `cs_n` fall in FILL sets `underrun`; `miso` stays 0.
- FULL state
  - `in_ready=0`, `frame_ready=1`.
  - On detected `cs_n` fall: `shreg<=buf[0]`, `rd_word<=0`, `bit_cnt<=DATA_WIDTH-1`, clear `underrun`, go to XMIT.
- XMIT state
  - `miso = shreg[MSB]`.
  - On detected `sclk` fall: shift left, decrement `bit_cnt`.
  - When `bit_cnt==0` and more words remain: load `buf[rd_word+1]`, `bit_cnt<=DATA_WIDTH-1`.
  - After the last bit of word `TOTAL_WORDS-1`: go to DONE, `miso=0`.
  - A detected `sclk` rise only marks progress; no state changes on it.
- DONE state
  - `miso=0`, further `sclk` ignored.
  - On detected `cs_n` rise: `frame_ready<=0`, `wr_ptr<=0` -> FILL.
- Abort: a detected `cs_n` rise in XMIT pulses `xfer_abort` for 1 cycle and returns to FULL. The frame is kept and the next transfer restarts at word 0.
- `miso` is 0 whenever `cs_n` (synced) is high or the state is not XMIT. It is never tri-stated.
- `in_valid` while `in_ready=0` is ignored; the word is not consumed.
- `frame_ready` falls only on completed readout.

## Timing
- Reset values: state FILL, `in_ready=1`, `miso=0`, `frame_ready=0`, `xfer_abort=0`, `underrun=0`, all pointers and counters 0.
- Input write: 1 word per cycle max. `frame_ready` rises the cycle after the final accept.
- Edge detect latency: 3 `clk` cycles from pin edge to detected edge.
- After `cs_n` fall, `miso` shows `buf[0][MSB]` within 4 `clk`.
- After each `sclk` fall, `miso` updates within 4 `clk`. With `f_clk >= 8*f_sclk` this is stable before the next host sample on `sclk` rise.
- `cs_n` is low for at least 4 `clk` before the first `sclk` rise.
- Reset mid-transfer aborts immediately with no `xfer_abort` pulse; the buffer contents are don't-care.
  - Because the sync FFs reset to idle, a `cs_n` held low through reset produces no fall.
  - The host must raise `cs_n` and lower it again to start a transfer.
- Simultaneous `cs_n` rise and `sclk` fall in the same detect cycle: the abort wins and no shift occurs.

## Test plan
- Fill: 8 words AAAA, 1234, 0F0F, 00FF, 8001, 7FFF, 55AA, DEAD with `in_valid` held -> `in_ready` drops and `frame_ready=1` after the 8th accept; a 9th valid word is not consumed.
- Readout: `f_clk=100 MHz`, `sclk` at 10 MHz, `cs_n` low for 128 bits -> host captures the 8 words above in order. Then `cs_n` high -> `frame_ready=0`, `in_ready=1`.
- Abort: raise `cs_n` after 20 bits -> `xfer_abort` pulses once and `frame_ready` stays 1. The retry returns AAAA first and then all 8 words.
- Underrun: lower `cs_n` after only 3 words are loaded -> `underrun=1`, `miso=0` throughout. Finish the fill and read out -> `underrun` clears at the `cs_n` fall and the data is correct.
- Bubbled input: `in_valid` toggling every other cycle with signed values 8000, FFFF -> stored and returned bit-exact.
- Reset at bit 50 with `cs_n` held low -> all outputs return to reset values and no transfer starts until `cs_n` goes high then low again.
